// File: rtl/conversor_bin_bcd_secuencial.sv
// rtl/conversor_bin_bcd_secuencial.sv - iterative shift-and-add-3 binary to BCD converter
// One input bit per cycle; signed inputs are converted as magnitude plus sign flag.
module conversor_bin_bcd_secuencial #(
  parameter int TAM_REG_BIN = 16,
  parameter int NUM_DIGITOS = 5
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       inicio,
  input  logic                       modo_signo,
  input  logic [TAM_REG_BIN-1:0]     dato_bin,
  output logic                       ocupado,
  output logic                       listo,
  output logic [4*NUM_DIGITOS-1:0]   reg_BCD,
  output logic                       negativo,
  output logic                       desborde
);

  localparam int W_BCD = 4 * NUM_DIGITOS;
  localparam int W_CNT = $clog2(TAM_REG_BIN + 1);

  typedef enum logic [1:0] {REPOSO, CONVIRTIENDO, FIN} estado_t;

  estado_t                estado, estado_sig;
  logic [TAM_REG_BIN-1:0] reg_desp;
  logic [TAM_REG_BIN-1:0] magnitud;
  logic [W_BCD-1:0]       acum;
  logic [W_BCD-1:0]       acum_aj;
  logic [W_CNT-1:0]       contador;
  logic                   signo_pend;
  logic                   desborde_acum;
  logic                   es_negativo;

  // The most negative value negates to 2^(N-1), which still fits as N-bit unsigned.
  always_comb begin
    es_negativo = modo_signo & dato_bin[TAM_REG_BIN-1];
    magnitud    = es_negativo ? (~dato_bin + TAM_REG_BIN'(1)) : dato_bin;
  end

  always_comb begin
    acum_aj = acum;
    for (int d = 0; d < NUM_DIGITOS; d++) begin
      if (acum[4*d +: 4] > 4'd4)
        acum_aj[4*d +: 4] = acum[4*d +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      estado <= REPOSO;
    else
      estado <= estado_sig;
  end

  always_comb begin
    estado_sig = estado;
    case (estado)
      REPOSO:       if (inicio) estado_sig = CONVIRTIENDO;
      CONVIRTIENDO: if (contador == W_CNT'(1)) estado_sig = FIN;
      FIN:          estado_sig = REPOSO;
      default:      estado_sig = REPOSO;
    endcase
  end

  always_comb begin
    ocupado = (estado != REPOSO);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      reg_desp      <= '0;
      acum          <= '0;
      contador      <= '0;
      signo_pend    <= 1'b0;
      desborde_acum <= 1'b0;
      reg_BCD       <= '0;
      negativo      <= 1'b0;
      desborde      <= 1'b0;
      listo         <= 1'b0;
    end else begin
      listo <= 1'b0;
      case (estado)
        REPOSO: begin
          if (inicio) begin
            reg_desp      <= magnitud;
            signo_pend    <= es_negativo;
            acum          <= '0;
            desborde_acum <= 1'b0;
            contador      <= W_CNT'(TAM_REG_BIN);
          end
        end
        CONVIRTIENDO: begin
          acum     <= {acum_aj[W_BCD-2:0], reg_desp[TAM_REG_BIN-1]};
          reg_desp <= reg_desp << 1;
          contador <= contador - W_CNT'(1);
          // A set top bit after adjustment means the value has outgrown D digits.
          if (acum_aj[W_BCD-1])
            desborde_acum <= 1'b1;
        end
        FIN: begin
          reg_BCD  <= acum;
          negativo <= signo_pend;
          desborde <= desborde_acum;
          listo    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bin_bcd_secuencial.sv
// tb/tb_conversor_bin_bcd_secuencial.sv - self-checking bench for the sequential BCD converter
module tb_conversor_bin_bcd_secuencial;

  logic        clk = 1'b0;
  logic        reset, inicio, modo_signo;
  logic [15:0] dato_bin;
  logic        ocupado, listo, negativo, desborde;
  logic [19:0] reg_bcd;
  logic        ocupado4, listo4, negativo4, desborde4;
  logic [15:0] reg_bcd4;
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  conversor_bin_bcd_secuencial #(.TAM_REG_BIN(16), .NUM_DIGITOS(5)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .modo_signo(modo_signo), .dato_bin(dato_bin),
    .ocupado(ocupado), .listo(listo), .reg_BCD(reg_bcd), .negativo(negativo), .desborde(desborde)
  );

  conversor_bin_bcd_secuencial #(.TAM_REG_BIN(16), .NUM_DIGITOS(4)) dut4 (
    .clk(clk), .reset(reset), .inicio(inicio), .modo_signo(modo_signo), .dato_bin(dato_bin),
    .ocupado(ocupado4), .listo(listo4), .reg_BCD(reg_bcd4), .negativo(negativo4), .desborde(desborde4)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int unsigned magnitud_de(input logic [15:0] d, input logic m);
    if (m && d[15]) return 32'd65536 - int'(d);
    return int'(d);
  endfunction

  function automatic logic [31:0] a_bcd(input int unsigned v, input int dig);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < dig; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  // Caller is in the idle state, just after a rising edge.
  task automatic convertir(input logic [15:0] d, input logic m, input string tag);
    int unsigned mag;
    int          n;
    bit          visto, caido;
    logic [19:0] bcd_fin;
    mag = magnitud_de(d, m);
    dato_bin = d; modo_signo = m; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0; dato_bin = 16'($urandom); modo_signo = 1'($urandom);
    n = 0; visto = 0; caido = 0;
    while (n < 40 && !visto) begin
      @(posedge clk); #1;
      n++;
      if (listo) visto = 1;
      else if (!ocupado) caido = 1;
    end
    check_eq({tag, "_latency"}, n, 17);
    check_eq({tag, "_busy_held"}, caido, 0);
    check_eq({tag, "_listo_d4"}, listo4, 1);
    check_eq({tag, "_ocupado_end"}, ocupado, 0);
    check_eq({tag, "_bcd5"}, reg_bcd, a_bcd(mag, 5));
    check_eq({tag, "_neg5"}, negativo, m & d[15]);
    check_eq({tag, "_ovf5"}, desborde, mag >= 100000);
    check_eq({tag, "_bcd4"}, reg_bcd4, a_bcd(mag, 4));
    check_eq({tag, "_neg4"}, negativo4, m & d[15]);
    check_eq({tag, "_ovf4"}, desborde4, mag >= 10000);
    bcd_fin = reg_bcd;
    @(posedge clk); #1;
    check_eq({tag, "_listo_pulse"}, listo, 0);
    check_eq({tag, "_bcd_hold"}, reg_bcd, a_bcd(mag, 5));
  endtask

  initial begin
    int          nl, n;
    bit          caido, visto;
    logic [19:0] captura;

    reset = 1'b1; inicio = 1'b0; modo_signo = 1'b0; dato_bin = '0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ocupado", ocupado, 0);
    check_eq("rst_listo", listo, 0);
    check_eq("rst_bcd", reg_bcd, 0);
    check_eq("rst_neg", negativo, 0);
    check_eq("rst_ovf", desborde, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    convertir(16'd0, 1'b0, "zero");
    convertir(16'hFFFF, 1'b0, "ffff_u");
    convertir(16'hFFFF, 1'b1, "ffff_s");
    convertir(16'h8000, 1'b1, "8000_s");
    convertir(16'h8000, 1'b0, "8000_u");
    convertir(16'd9999, 1'b0, "9999");
    convertir(16'd12345, 1'b0, "12345");
    convertir(16'h0000, 1'b1, "zero_s");

    // Second start while busy must be ignored
    dato_bin = 16'd100; modo_signo = 1'b0; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    dato_bin = 16'd200; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    nl = 0; caido = 0; captura = '0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (listo) begin
        nl++;
        if (nl == 1) captura = reg_bcd;
      end else if (nl == 0 && !ocupado) caido = 1;
    end
    check_eq("dbl_listo_count", nl, 1);
    check_eq("dbl_busy_held", caido, 0);
    check_eq("dbl_bcd", captura, 20'h00100);

    // Reset between shift edges 7 and 8 aborts the conversion
    dato_bin = 16'd4321; inicio = 1'b1;
    @(posedge clk); #1;
    inicio = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_eq("abort_ocupado", ocupado, 0);
    check_eq("abort_bcd", reg_bcd, 0);
    check_eq("abort_listo", listo, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    nl = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (listo) nl++;
    end
    check_eq("abort_no_listo", nl, 0);
    convertir(16'd4321, 1'b0, "4321");

    // inicio held high: completions every N+2 cycles
    dato_bin = 16'd7; modo_signo = 1'b0; inicio = 1'b1;
    visto = 0; n = 0;
    while (n < 40 && !visto) begin
      @(posedge clk); #1;
      n++;
      if (listo) visto = 1;
    end
    check_eq("b2b_first", visto, 1);
    visto = 0; n = 0;
    while (n < 40 && !visto) begin
      @(posedge clk); #1;
      n++;
      if (listo) visto = 1;
    end
    inicio = 1'b0;
    check_eq("b2b_period", n, 18);
    check_eq("b2b_bcd", reg_bcd, 20'h00007);

    for (int k = 0; k < 30; k++)
      convertir(16'($urandom), 1'($urandom), $sformatf("rnd%0d", k));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conversor_bin_bcd_secuencial.md
Name: conversor_bin_bcd_secuencial

Overview:
Iterative, clocked binary-to-BCD converter (shift-and-add-3), one input bit per cycle, for the seven-segment display path.
Generalised in input width and BCD digit count, with a runtime signed/unsigned mode and an overflow flag.
Uses a start/busy/done handshake, so the display controller can issue a conversion and latch the packed BCD result on completion.
Replaces the wide combinational converter, removing its long combinational path.

Parameters:
TAM_REG_BIN, 16, binary input width N (N >= 4).
NUM_DIGITOS, 5, number of BCD output digits D (D >= 1); result width 4*D.

Ports:
clk  input  1  system clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
inicio  input  1  start request; sampled only in REPOSO.
modo_signo  input  1  sampled with inicio: 1 = dato_bin is two's complement, 0 = unsigned.
dato_bin  input  N  binary value; sampled with inicio.
ocupado  output  1  high while a conversion is in progress.
listo  output  1  one-cycle completion pulse.
reg_BCD  output  4*D  packed BCD result; digit 0 (units) in bits [3:0].
negativo  output  1  sign of the last completed result.
desborde  output  1  last result did not fit in D digits.

Behaviour:
- Reset (async, any state): state=REPOSO; ocupado, listo, negativo, desborde=0; reg_BCD=0; internal shift, BCD and counter registers=0. Reset mid-conversion aborts it, and no listo is produced.
- States: REPOSO, CONVIRTIENDO, FIN.
- REPOSO: if inicio=1 at edge E0, go to CONVIRTIENDO and set ocupado=1.
  - Capture magnitude: if modo_signo=1 and dato_bin[N-1]=1, capture two's-complement negation as N-bit unsigned (-2^(N-1) -> 2^(N-1), fits); otherwise capture dato_bin.
  - Latch sign_pend = modo_signo & dato_bin[N-1].
  - Clear BCD accumulator and overflow accumulator; counter = N.
- CONVIRTIENDO, at each edge:
  - For every digit d in 0..D-1 of the accumulator, if digit > 4, add 3 (all digits in parallel, computed from the pre-edge value).
  - Shift the adjusted accumulator left 1, inserting the shift register MSB at bit 0.
  - Shift the shift register left 1.
  - If the adjusted accumulator's bit 4*D-1 was 1, set the overflow accumulator (sticky).
  - Decrement counter. The edge where counter goes 1->0 moves to FIN. Exactly N shift edges (E1..EN).
- FIN, at edge EN+1:
  - reg_BCD <= accumulator; negativo <= sign_pend; desborde <= overflow accumulator.
  - listo=1 for the following cycle only; ocupado=0; state=REPOSO.
  - Latency: inicio sampled at E0 -> listo and new reg_BCD visible after E(N+1); ocupado high for N+1 cycles.
- inicio while ocupado=1 is ignored, with no queueing. inicio held high continuously starts a new conversion on the edge after listo, i.e. back-to-back every N+2 cycles.
- dato_bin and modo_signo changes after E0 have no effect on the conversion in progress.
- reg_BCD, negativo and desborde hold their values between completions. On desborde=1, reg_BCD holds the low D digits of the truncated result, with no saturation.
- Zero input gives reg_BCD=0 and negativo=0. Signed zero cannot produce negativo=1.

Test Plan:
- N=16, D=5: reset, then inicio with dato_bin=0, modo_signo=0 -> listo after exactly 17 edges; reg_BCD=0x00000, negativo=0, desborde=0.
- N=16, D=5: dato_bin=16'hFFFF, modo_signo=0 -> reg_BCD=0x65535; same data with modo_signo=1 -> reg_BCD=0x00001, negativo=1.
- N=16, D=5: dato_bin=16'h8000 with modo_signo=1 -> reg_BCD=0x32768, negativo=1; with modo_signo=0 -> reg_BCD=0x32768, negativo=0.
- N=16, D=4: dato_bin=9999 -> reg_BCD=0x9999, desborde=0; dato_bin=12345 -> desborde=1, reg_BCD=0x2345.
- Pulse inicio (dato_bin=100) and, 5 cycles later, inicio again with dato_bin=200 -> single listo, reg_BCD=0x00100; ocupado never drops in between.
- Assert reset at shift edge 8 of a conversion of 4321 -> ocupado=0, reg_BCD=0, no listo. Then convert 4321 -> reg_BCD=0x04321 after 17 edges.
